// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, XLEN+2 cycle latency.
// Valid/ready on both sides; result is held in DONE until consumed, flush aborts at any point.
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] d1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            last_bit
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_nx;
  logic [2:0]          op_q;
  logic                sign_a, sign_b;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opb;
  logic [XLEN-1:0]     rem;
  logic [CW-1:0]       cnt;

  logic                a_signed, b_signed, take;
  logic [XLEN:0]       mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rmd, result_d;

  assign a_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
  assign b_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign take     = (state == IDLE) && in_valid && !flush;

  // Multiply: acc = {partial product, remaining multiplier}; divide: acc low half shifts dividend out, quotient in.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
  assign div_sh   = {rem, acc[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opb};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = CALC;
      CALC: if (cnt == CW'(XLEN-1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Divide-by-zero yields an all-ones quotient and the dividend as remainder; only the quotient sign must be suppressed.
  // Signed overflow needs no special handling: |MIN|/1 = MIN with no negation, remainder 0.
  always_comb begin
    prod = (sign_a ^ sign_b) ? -acc : acc;
    quo  = ((sign_a ^ sign_b) && (opb != '0)) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd  = sign_a ? -rem : rem;
    if (!op_q[2]) begin
      result_d = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      result_d = op_q[1] ? rmd : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      rem    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (take) begin
      op_q   <= op;
      sign_a <= a_signed & d1[XLEN-1];
      sign_b <= b_signed & rs2[XLEN-1];
      acc    <= {{XLEN{1'b0}}, (a_signed && d1[XLEN-1]) ? -d1 : d1};
      opb    <= (b_signed && rs2[XLEN-1]) ? -rs2 : rs2;
      rem    <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      if (!op_q[2]) begin
        acc <= {mul_sum, acc[XLEN-1:1]};
      end else if (!div_diff[XLEN]) begin
        rem             <= div_diff[XLEN-1:0];
        acc[XLEN-1:0]   <= {acc[XLEN-2:0], 1'b1};
      end else begin
        rem             <= div_sh[XLEN-1:0];
        acc[XLEN-1:0]   <= {acc[XLEN-2:0], 1'b0};
      end
    end else if ((state == FIX) && !flush) begin
      result <= result_d;
    end
  end

  assign zero     = (result == '0);
  assign last_bit = result[0];

endmodule
